// File: rtl/tone_osc_pkg.sv
// tone_osc_pkg: shared constants and types for the tone oscillator bank.
//   CNT_W_DEF  - default period/high-time counter width (50 MHz down to 1 Hz)
//   MIN_PERIOD - shortest period that produces a waveform; shorter is silent
//   tone_cfg_t - {period, high} record at the default width
package tone_osc_pkg;

    localparam int CNT_W_DEF  = 26;
    localparam int MIN_PERIOD = 2;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] high;
    } tone_cfg_t;

endpackage

// File: rtl/tone_osc_channel.sv
// tone_osc_channel: one square/PWM voice.
// Holds the phase counter, active and shadow {period, high} registers and the
// pending flag. Shadow values move to active when the period wraps, when the
// channel is not running, or on a sync pulse.
// Ports:
//   clock, clr     - clock, async active-high reset
//   en             - run enable
//   sync           - hard sync: restart phase, no tick (tied low when unused)
//   wr_act         - load active regs now and restart phase
//   wr_sh          - load shadow regs and mark pending
//   wr_period/high - write data
//   pend           - shadow holds an uncommitted value
//   osc_out        - registered oscillator output
//   period_tick    - registered pulse marking the last output cycle of a period
module tone_osc_channel
    import tone_osc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_act,
    input  logic             wr_sh,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_high,
    output logic             pend,
    output logic             osc_out,
    output logic             period_tick
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
    } cfg_t;

    cfg_t             act;
    cfg_t             sh;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             run;
    logic             wrap;
    logic             restart;
    logic             commit;

    always_comb begin
        run     = en && (act.period >= CNT_W'(MIN_PERIOD));
        // >= rather than == so a stray count above the period still wraps
        wrap    = run && (cnt >= act.period - CNT_W'(1));
        restart = !run || sync || wrap;
        commit  = pend && restart;
        cnt_d   = cnt + CNT_W'(1);
        if (wr_act || restart)
            cnt_d = '0;
    end

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            cnt         <= '0;
            act         <= '0;
            sh          <= '0;
            pend        <= 1'b0;
            osc_out     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            cnt <= cnt_d;
            // a direct write wins over a commit landing on the same cycle
            if (wr_act) begin
                act.period <= wr_period;
                act.high   <= wr_high;
            end else if (commit) begin
                act  <= sh;
                pend <= 1'b0;
            end
            if (wr_sh) begin
                sh.period <= wr_period;
                sh.high   <= wr_high;
                pend      <= 1'b1;
            end
            // both outputs reflect the previous count, so the tick lines up
            // with the last output cycle of the period
            osc_out     <= run && (cnt < act.high);
            period_tick <= wrap && !sync;
        end
    end

endmodule

// File: rtl/tone_osc_bank.sv
// tone_osc_bank: CHANNELS independent programmable square/PWM oscillators.
// Optional build macro TONE_OSC_BANK_SYNC_EN adds sync_in (per-channel hard
// sync); without it the port is absent and sync is never asserted.
// Ports:
//   clock, clr          - clock, async active-high reset
//   wr_valid/wr_ready   - write handshake; ready is low while target is pending
//   wr_ch               - target channel; out-of-range writes are dropped
//   wr_period, wr_high  - period and high-time in clock cycles
//   wr_now              - 1: load active and restart; 0: commit at period end
//   ch_en               - per-channel run enable
//   sync_in             - (TONE_OSC_BANK_SYNC_EN only) hard-sync pulses
//   osc_out             - oscillator outputs
//   period_tick         - one pulse per period per channel
module tone_osc_bank
    import tone_osc_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int CNT_W    = CNT_W_DEF,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                clr,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_period,
    input  logic [CNT_W-1:0]    wr_high,
    input  logic                wr_now,
    input  logic [CHANNELS-1:0] ch_en,
`ifdef TONE_OSC_BANK_SYNC_EN
    input  logic [CHANNELS-1:0] sync_in,
`endif
    output logic [CHANNELS-1:0] osc_out,
    output logic [CHANNELS-1:0] period_tick
);

    localparam int PAD = 1 << CH_W;

    logic [CHANNELS-1:0] pend;
    logic [PAD-1:0]      pend_pad;
    logic [CHANNELS-1:0] sync_vec;
    logic                accept;

`ifdef TONE_OSC_BANK_SYNC_EN
    assign sync_vec = sync_in;
`else
    assign sync_vec = '0;
`endif

    // Padding makes out-of-range channels read as not pending, so they are
    // always ready; no channel decodes them, so the write is dropped.
    assign pend_pad = PAD'(pend);
    assign wr_ready = ~pend_pad[wr_ch];
    assign accept   = wr_valid && wr_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic sel;
        assign sel = accept && (wr_ch == CH_W'(i));

        tone_osc_channel #(.CNT_W(CNT_W)) u_ch (
            .clock       (clock),
            .clr         (clr),
            .en          (ch_en[i]),
            .sync        (sync_vec[i]),
            .wr_act      (sel && wr_now),
            .wr_sh       (sel && !wr_now),
            .wr_period   (wr_period),
            .wr_high     (wr_high),
            .pend        (pend[i]),
            .osc_out     (osc_out[i]),
            .period_tick (period_tick[i])
        );
    end

endmodule

// File: tb/tb_tone_osc_bank.sv
module tb_tone_osc_bank;

    localparam int CHANNELS = 3;
    localparam int CNT_W    = 26;
    localparam int CH_W     = 2;

    logic                clock = 1'b0;
    logic                clr;
    logic                wr_valid;
    logic                wr_ready;
    logic [CH_W-1:0]     wr_ch;
    logic [CNT_W-1:0]    wr_period;
    logic [CNT_W-1:0]    wr_high;
    logic                wr_now;
    logic [CHANNELS-1:0] ch_en;
    logic [CHANNELS-1:0] osc_out;
    logic [CHANNELS-1:0] period_tick;
`ifdef TONE_OSC_BANK_SYNC_EN
    logic [CHANNELS-1:0] sync_in;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    tone_osc_bank #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .clr         (clr),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_ch       (wr_ch),
        .wr_period   (wr_period),
        .wr_high     (wr_high),
        .wr_now      (wr_now),
        .ch_en       (ch_en),
`ifdef TONE_OSC_BANK_SYNC_EN
        .sync_in     (sync_in),
`endif
        .osc_out     (osc_out),
        .period_tick (period_tick)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_wr(input int ch, input int p, input int h, input bit now);
        wr_valid  = 1'b1;
        wr_ch     = CH_W'(ch);
        wr_period = CNT_W'(p);
        wr_high   = CNT_W'(h);
        wr_now    = now;
    endtask

    task automatic do_wr(input int ch, input int p, input int h, input bit now);
        drive_wr(ch, p, h, now);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; wr_valid = 1'b0; wr_ch = '0; wr_period = '0; wr_high = '0;
        wr_now = 1'b0; ch_en = '0;
`ifdef TONE_OSC_BANK_SYNC_EN
        sync_in = '0;
`endif
        step(); step();
        n_chk++; if (osc_out !== 3'b000) $display("FAIL reset_osc got=%b exp=000", osc_out); else n_pass++;
        n_chk++; if (period_tick !== 3'b000) $display("FAIL reset_tick got=%b exp=000", period_tick); else n_pass++;
        n_chk++; if (wr_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", wr_ready); else n_pass++;
        clr = 1'b0;
        ch_en = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_chk++; if (osc_out !== 3'b000 || period_tick !== 3'b000)
                $display("FAIL idle_after_reset osc=%b tick=%b exp=000/000", osc_out, period_tick);
            else n_pass++;
        end
    endtask

    // 5 high / 5 low, tick every 10; an out-of-range write mid-run is dropped
    task automatic test_basic();
        bit eo, et;
        do_wr(0, 10, 5, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            if (k == 13) begin
                drive_wr(3, 2, 0, 1'b1);
                n_chk++; if (wr_ready !== 1'b1) $display("FAIL oob_ready got=%b exp=1", wr_ready); else n_pass++;
            end
            step();
            wr_valid = 1'b0;
            eo = ((k - 1) % 10) < 5;
            et = ((k - 1) % 10) == 9;
            n_chk++; if (osc_out[0] !== eo) $display("FAIL basic_osc k=%0d got=%b exp=%b", k, osc_out[0], eo); else n_pass++;
            n_chk++; if (period_tick[0] !== et) $display("FAIL basic_tick k=%0d got=%b exp=%b", k, period_tick[0], et); else n_pass++;
        end
    endtask

    // shadow write at cnt=3: old waveform finishes, then 1 high / 3 low
    task automatic test_shadow();
        bit eo, et, er;
        int m;
        do_wr(0, 10, 5, 1'b1);
        step(); step(); step();
        drive_wr(0, 4, 1, 1'b0);
        n_chk++; if (wr_ready !== 1'b1) $display("FAIL shadow_ready_pre got=%b exp=1", wr_ready); else n_pass++;
        step();
        wr_valid = 1'b0;
        n_chk++; if (wr_ready !== 1'b0) $display("FAIL shadow_ready_blk got=%b exp=0", wr_ready); else n_pass++;
        for (int k = 5; k <= 18; k++) begin
            step();
            if (k <= 10) begin
                eo = (k - 1) < 5;
                et = (k == 10);
                er = (k == 10);
                n_chk++; if (wr_ready !== er) $display("FAIL shadow_ready k=%0d got=%b exp=%b", k, wr_ready, er); else n_pass++;
            end else begin
                m  = k - 11;
                eo = (m % 4) == 0;
                et = (m % 4) == 3;
            end
            n_chk++; if (osc_out[0] !== eo) $display("FAIL shadow_osc k=%0d got=%b exp=%b", k, osc_out[0], eo); else n_pass++;
            n_chk++; if (period_tick[0] !== et) $display("FAIL shadow_tick k=%0d got=%b exp=%b", k, period_tick[0], et); else n_pass++;
        end
    endtask

    // high=0 -> constant low; high>period -> constant high; ticks every 8
    task automatic test_const();
        bit et;
        do_wr(1, 8, 0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            step();
            et = ((k - 1) % 8) == 7;
            n_chk++; if (osc_out[1] !== 1'b0) $display("FAIL low_osc k=%0d got=%b exp=0", k, osc_out[1]); else n_pass++;
            n_chk++; if (period_tick[1] !== et) $display("FAIL low_tick k=%0d got=%b exp=%b", k, period_tick[1], et); else n_pass++;
        end
        do_wr(1, 8, 20, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            step();
            et = ((k - 1) % 8) == 7;
            n_chk++; if (osc_out[1] !== 1'b1) $display("FAIL high_osc k=%0d got=%b exp=1", k, osc_out[1]); else n_pass++;
            n_chk++; if (period_tick[1] !== et) $display("FAIL high_tick k=%0d got=%b exp=%b", k, period_tick[1], et); else n_pass++;
        end
    endtask

    // period=1 is silent; a shadow write commits next clock and starts 1/2
    task automatic test_silent();
        bit eo, et;
        do_wr(2, 1, 1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step();
            n_chk++; if (osc_out[2] !== 1'b0 || period_tick[2] !== 1'b0)
                $display("FAIL silent k=%0d osc=%b tick=%b exp=0/0", k, osc_out[2], period_tick[2]);
            else n_pass++;
        end
        drive_wr(2, 3, 1, 1'b0);
        n_chk++; if (wr_ready !== 1'b1) $display("FAIL silent_ready_pre got=%b exp=1", wr_ready); else n_pass++;
        step();
        wr_valid = 1'b0;
        n_chk++; if (wr_ready !== 1'b0) $display("FAIL silent_ready_pend got=%b exp=0", wr_ready); else n_pass++;
        step();
        n_chk++; if (wr_ready !== 1'b1) $display("FAIL silent_ready_commit got=%b exp=1", wr_ready); else n_pass++;
        n_chk++; if (osc_out[2] !== 1'b0) $display("FAIL silent_commit_osc got=%b exp=0", osc_out[2]); else n_pass++;
        for (int k = 2; k <= 10; k++) begin
            step();
            eo = ((k - 2) % 3) == 0;
            et = ((k - 2) % 3) == 2;
            n_chk++; if (osc_out[2] !== eo) $display("FAIL start_osc k=%0d got=%b exp=%b", k, osc_out[2], eo); else n_pass++;
            n_chk++; if (period_tick[2] !== et) $display("FAIL start_tick k=%0d got=%b exp=%b", k, period_tick[2], et); else n_pass++;
        end
    endtask

    task automatic test_enable();
        bit eo, et;
        do_wr(0, 10, 5, 1'b1);
        step(); step();
        n_chk++; if (osc_out[0] !== 1'b1) $display("FAIL en_pre_osc got=%b exp=1", osc_out[0]); else n_pass++;
        ch_en[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_chk++; if (osc_out[0] !== 1'b0 || period_tick[0] !== 1'b0)
                $display("FAIL en_off k=%0d osc=%b tick=%b exp=0/0", k, osc_out[0], period_tick[0]);
            else n_pass++;
        end
        ch_en[0] = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step();
            eo = ((j - 1) % 10) < 5;
            et = ((j - 1) % 10) == 9;
            n_chk++; if (osc_out[0] !== eo) $display("FAIL reen_osc j=%0d got=%b exp=%b", j, osc_out[0], eo); else n_pass++;
            n_chk++; if (period_tick[0] !== et) $display("FAIL reen_tick j=%0d got=%b exp=%b", j, period_tick[0], et); else n_pass++;
        end
    endtask

    // async clear mid-period with a pending write outstanding
    task automatic test_clr();
        do_wr(0, 10, 5, 1'b1);
        step(); step();
        do_wr(0, 4, 1, 1'b0);
        n_chk++; if (wr_ready !== 1'b0) $display("FAIL clr_pre_ready got=%b exp=0", wr_ready); else n_pass++;
        n_chk++; if (osc_out[1:0] !== 2'b11) $display("FAIL clr_pre_osc got=%b exp=11", osc_out[1:0]); else n_pass++;
        #2 clr = 1'b1;
        #1;
        n_chk++; if (osc_out !== 3'b000) $display("FAIL clr_osc got=%b exp=000", osc_out); else n_pass++;
        n_chk++; if (period_tick !== 3'b000) $display("FAIL clr_tick got=%b exp=000", period_tick); else n_pass++;
        n_chk++; if (wr_ready !== 1'b1) $display("FAIL clr_ready got=%b exp=1", wr_ready); else n_pass++;
        #1 clr = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_chk++; if (osc_out !== 3'b000 || period_tick !== 3'b000 || wr_ready !== 1'b1)
                $display("FAIL post_clr k=%0d osc=%b tick=%b rdy=%b exp=000/000/1", k, osc_out, period_tick, wr_ready);
            else n_pass++;
        end
    endtask

`ifdef TONE_OSC_BANK_SYNC_EN
    task automatic test_sync();
        bit eo, et;
        do_wr(0, 10, 5, 1'b1);
        for (int k = 1; k <= 6; k++) step();
        sync_in[0] = 1'b1;
        step();
        sync_in[0] = 1'b0;
        n_chk++; if (osc_out[0] !== 1'b0 || period_tick[0] !== 1'b0)
            $display("FAIL sync6 osc=%b tick=%b exp=0/0", osc_out[0], period_tick[0]);
        else n_pass++;
        for (int j = 1; j <= 19; j++) begin
            step();
            eo = ((j - 1) % 10) < 5;
            et = ((j - 1) % 10) == 9;
            n_chk++; if (osc_out[0] !== eo) $display("FAIL sync_osc j=%0d got=%b exp=%b", j, osc_out[0], eo); else n_pass++;
            n_chk++; if (period_tick[0] !== et) $display("FAIL sync_tick j=%0d got=%b exp=%b", j, period_tick[0], et); else n_pass++;
        end
        // counter now at 9: sync on the wrap cycle must suppress the tick
        sync_in[0] = 1'b1;
        step();
        sync_in[0] = 1'b0;
        n_chk++; if (period_tick[0] !== 1'b0) $display("FAIL sync9_tick got=%b exp=0", period_tick[0]); else n_pass++;
        step();
        n_chk++; if (osc_out[0] !== 1'b1) $display("FAIL sync9_restart got=%b exp=1", osc_out[0]); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_shadow();
        test_const();
        test_silent();
        test_enable();
        test_clr();
`ifdef TONE_OSC_BANK_SYNC_EN
        test_sync();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
